nn_mac_accum: RTL and testbench

- Downstream consumer of the unsigned 25x6 -> 31-bit product multiplier in the AlexNet compute datapath.
- Accepts a stream of 31-bit unsigned products, one per kernel tap, and sums each packet into a wide accumulator.
- At packet end it emits one rounded, right-shifted, saturated unsigned activation toward the output/pooling stage.
- Valid/ready handshake on both sides; single clock.

---
 rtl/nn_mac_accum.sv | 117 +++++++++++
 tb/tb_nn_mac_accum.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nn_mac_accum.sv
// rtl/nn_mac_accum.sv - packet accumulator with rounded, shifted, saturated activation output
module nn_mac_accum #(
  parameter int PROD_W  = 31,
  parameter int ACC_W   = 40,
  parameter int OUT_W   = 16,
  parameter int SHIFT   = 8,
  parameter int MAX_LEN = 4096,
  parameter int CNT_W   = 13
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] in_prod,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_sat,
  output logic              out_err_len,
  output logic              out_valid,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_EMIT
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               acc_ovf;

  logic               accept;
  logic [ACC_W:0]     sum_wide;
  logic [ACC_W-1:0]   sum_sat;
  logic               ovf_now;
  logic [CNT_W-1:0]   cnt_next;
  logic               at_max;
  logic               close_pkt;
  logic [ACC_W:0]     rounded;
  logic               sat_next;
  logic [OUT_W-1:0]   data_next;

  assign in_ready = (state != S_EMIT);
  assign accept   = in_valid && in_ready;

  // In IDLE the incoming beat starts a fresh sum, so the stale accumulator is masked off.
  always_comb begin
    sum_wide  = ((state == S_IDLE) ? '0 : {1'b0, acc})
              + {{(ACC_W + 1 - PROD_W){1'b0}}, in_prod};
    ovf_now   = sum_wide[ACC_W] || ((state != S_IDLE) && acc_ovf);
    sum_sat   = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    cnt_next  = (state == S_IDLE) ? CNT_W'(1) : cnt + 1'b1;
    at_max    = (cnt_next == CNT_W'(MAX_LEN));
    close_pkt = in_last || at_max;
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic [ACC_W:0] HALF = (ACC_W + 1)'(1) << (SHIFT - 1);
      assign rounded = ({1'b0, sum_sat} + HALF) >> SHIFT;
    end else begin : g_noround
      assign rounded = {1'b0, sum_sat};
    end
  endgenerate

  always_comb begin
    sat_next  = |rounded[ACC_W:OUT_W];
    data_next = sat_next ? '1 : rounded[OUT_W-1:0];
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      cnt         <= '0;
      acc_ovf     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_count   <= '0;
      out_sat     <= 1'b0;
      out_err_len <= 1'b0;
    end else begin
      case (state)
        S_EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          if (accept) begin
            if (close_pkt) begin
              out_valid   <= 1'b1;
              out_data    <= data_next;
              out_count   <= cnt_next;
              out_sat     <= sat_next || ovf_now;
              out_err_len <= at_max && !in_last;
              acc         <= '0;
              cnt         <= '0;
              acc_ovf     <= 1'b0;
              state       <= S_EMIT;
            end else begin
              acc     <= sum_sat;
              cnt     <= cnt_next;
              acc_ovf <= ovf_now;
              state   <= S_ACCUM;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_mac_accum.sv
// tb/tb_nn_mac_accum.sv - directed self-checking bench for nn_mac_accum
module tb_nn_mac_accum;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic [30:0] in_prod;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic [12:0] out_count;
  logic        out_sat;
  logic        out_err_len;
  logic        out_valid;
  logic        out_ready;

  int compared   = 0;
  int mismatched = 0;

  nn_mac_accum dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .in_prod     (in_prod),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_count   (out_count),
    .out_sat     (out_sat),
    .out_err_len (out_err_len),
    .out_valid   (out_valid),
    .out_ready   (out_ready)
  );

  always #5 ap_clk = ~ap_clk;

  // Offers one beat and returns #1 after the edge that accepted it.
  task automatic send_beat(input logic [30:0] p, input logic l);
    int n = 0;
    in_prod  = p;
    in_last  = l;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge ap_clk); #1;
      n++;
    end
    compared++;
    if (n >= 20) begin
      mismatched++;
      $display("FAIL beat_accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset;
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    compared++;
    if ({out_valid, out_data, out_count, out_sat, out_err_len, in_ready} !== {1'b0, 16'd0, 13'd0, 1'b0, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL reset_state: v=%0b d=%0d c=%0d s=%0b e=%0b rdy=%0b required 0/0/0/0/0/1",
               out_valid, out_data, out_count, out_sat, out_err_len, in_ready);
    end
    ap_rst = 1'b0;
  endtask

  task automatic test_basic;
    send_beat(31'd100, 1'b0);
    send_beat(31'd200, 1'b0);
    send_beat(31'd300, 1'b1);
    compared++;
    if ({out_valid, out_data, out_count, out_sat, out_err_len} !== {1'b1, 16'd2, 13'd3, 1'b0, 1'b0}) begin
      mismatched++;
      $display("FAIL basic_output: v=%0b d=%0d c=%0d s=%0b e=%0b required 1/2/3/0/0",
               out_valid, out_data, out_count, out_sat, out_err_len);
    end
    @(posedge ap_clk); #1;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL basic_drain: v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single;
    send_beat(31'd384, 1'b1);
    compared++;
    if ({out_valid, out_data, out_count, in_ready} !== {1'b1, 16'd2, 13'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL single_output: v=%0b d=%0d c=%0d rdy=%0b required 1/2/1/0",
               out_valid, out_data, out_count, in_ready);
    end
    @(posedge ap_clk); #1;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL single_drain: v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_saturate;
    send_beat(31'h7FFF_FFFF, 1'b0);
    send_beat(31'h7FFF_FFFF, 1'b1);
    compared++;
    if ({out_data, out_count, out_sat, out_err_len} !== {16'hFFFF, 13'd2, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL sat_two_beats: d=%0h c=%0d s=%0b e=%0b required ffff/2/1/0",
               out_data, out_count, out_sat, out_err_len);
    end
    @(posedge ap_clk); #1;
    for (int i = 0; i < 513; i++) send_beat(31'h7FFF_FFFF, (i == 512));
    compared++;
    if ({out_valid, out_data, out_count, out_sat, out_err_len} !== {1'b1, 16'hFFFF, 13'd513, 1'b1, 1'b0}) begin
      mismatched++;
      $display("FAIL sat_acc_overflow: v=%0b d=%0h c=%0d s=%0b e=%0b required 1/ffff/513/1/0",
               out_valid, out_data, out_count, out_sat, out_err_len);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    send_beat(31'd1000, 1'b0);
    send_beat(31'd1000, 1'b1);
    in_prod  = 31'd5;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk); #1;
      compared++;
      if ({out_valid, out_data, out_count, out_sat, in_ready} !== {1'b1, 16'd8, 13'd2, 1'b0, 1'b0}) begin
        mismatched++;
        $display("FAIL bp_hold cycle %0d: v=%0b d=%0d c=%0d s=%0b rdy=%0b required 1/8/2/0/0",
                 i, out_valid, out_data, out_count, out_sat, in_ready);
      end
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(posedge ap_clk); #1;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL bp_release: v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
    @(posedge ap_clk); #1;
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL bp_no_leak: v=%0b required 0", out_valid);
    end
  endtask

  task automatic test_forced_close;
    for (int i = 0; i < 4096; i++) send_beat(31'd1, 1'b0);
    compared++;
    if ({out_valid, out_data, out_count, out_sat, out_err_len} !== {1'b1, 16'd16, 13'd4096, 1'b0, 1'b1}) begin
      mismatched++;
      $display("FAIL forced_close: v=%0b d=%0d c=%0d s=%0b e=%0b required 1/16/4096/0/1",
               out_valid, out_data, out_count, out_sat, out_err_len);
    end
    send_beat(31'd1, 1'b1);
    compared++;
    if ({out_valid, out_data, out_count, out_err_len} !== {1'b1, 16'd0, 13'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL after_forced_close: v=%0b d=%0d c=%0d e=%0b required 1/0/1/0",
               out_valid, out_data, out_count, out_err_len);
    end
    for (int i = 0; i < 4096; i++) send_beat(31'd1, (i == 4095));
    compared++;
    if ({out_valid, out_data, out_count, out_err_len} !== {1'b1, 16'd16, 13'd4096, 1'b0}) begin
      mismatched++;
      $display("FAIL last_at_max_len: v=%0b d=%0d c=%0d e=%0b required 1/16/4096/0",
               out_valid, out_data, out_count, out_err_len);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 10; i++) send_beat(31'd100, 1'b0);
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL mid_reset_state: v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
    send_beat(31'd256, 1'b0);
    send_beat(31'd256, 1'b1);
    compared++;
    if ({out_valid, out_data, out_count, out_sat} !== {1'b1, 16'd2, 13'd2, 1'b0}) begin
      mismatched++;
      $display("FAIL mid_reset_next_pkt: v=%0b d=%0d c=%0d s=%0b required 1/2/2/0",
               out_valid, out_data, out_count, out_sat);
    end
    @(posedge ap_clk); #1;
  endtask

  task automatic test_back_to_back;
    send_beat(31'd256, 1'b1);
    compared++;
    if ({out_valid, out_data, out_count} !== {1'b1, 16'd1, 13'd1}) begin
      mismatched++;
      $display("FAIL b2b_first: v=%0b d=%0d c=%0d required 1/1/1", out_valid, out_data, out_count);
    end
    in_prod  = 31'd512;
    in_last  = 1'b1;
    in_valid = 1'b1;
    @(posedge ap_clk); #1;
    compared++;
    if ({out_valid, in_ready} !== 2'b01) begin
      mismatched++;
      $display("FAIL b2b_gap: v=%0b rdy=%0b required 0/1", out_valid, in_ready);
    end
    @(posedge ap_clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    compared++;
    if ({out_valid, out_data, out_count} !== {1'b1, 16'd2, 13'd1}) begin
      mismatched++;
      $display("FAIL b2b_second: v=%0b d=%0d c=%0d required 1/2/1", out_valid, out_data, out_count);
    end
    @(posedge ap_clk); #1;
  endtask

  initial begin
    ap_rst    = 1'b1;
    in_prod   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    test_reset;
    test_basic;
    test_single;
    test_saturate;
    test_backpressure;
    test_forced_close;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
